// File: rtl/axi_txn_scheduler.sv
// axi_txn_scheduler
//   Round-robin scheduler sharing one AXI master transaction engine between
//   NUM_REQ requesters. One transaction is in flight at a time: arbitrate,
//   launch a single start pulse, wait for the master's completion, report
//   completion to the owning requester, then hold off GAP_CYCLES cycles.
//
// Ports
//   clk              rising-edge clock
//   reset            asynchronous, active-low reset
//   req_valid[N]     per-requester request, held until granted
//   req_write[N]     per-requester direction (1 write, 0 read), sampled at arbitration
//   req_grant[N]     one-hot, 1-cycle pulse when the requester's transaction launches
//   req_done[N]      one-hot, 1-cycle pulse when the requester's transaction completes
//   req_error        qualifies req_done: 1 = master error or timeout
//   start_write_txn  1-cycle start pulse to the master (write)
//   start_read_txn   1-cycle start pulse to the master (read)
//   txn_done         master completion pulse (ignored outside WAIT)
//   txn_error        master error flag, sampled with txn_done
//   busy             high while the scheduler is not idle
//   active_id        index of the owning requester; holds its last value in IDLE
//   dbg_state        current FSM state (0 IDLE, 1 LAUNCH, 2 WAIT, 3 GAP)
//
// Handshake: a requester raises req_valid and holds it; the one-cycle
// req_grant pulse consumes the request. req_valid still high after the grant
// is treated as a fresh request. Dropping req_valid before the grant simply
// withdraws it.
//
// Optional feature: define TXN_TIMEOUT_EN to add a WAIT watchdog that forces
// completion with req_error = 1 after TIMEOUT_CYCLES cycles without txn_done.
module axi_txn_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0]         req_write,
  output logic [NUM_REQ-1:0]         req_grant,
  output logic [NUM_REQ-1:0]         req_done,
  output logic                       req_error,
  output logic                       start_write_txn,
  output logic                       start_read_txn,
  input  logic                       txn_done,
  input  logic                       txn_error,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] active_id,
  output logic [1:0]                 dbg_state
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int GW  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  // Elaboration-time parameter sanity checks.
  if (NUM_REQ < 2) begin : g_bad_num_req
    $error("NUM_REQ must be at least 2");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    GAP    = 2'd3
  } state_t;

  state_t           state;
  logic [IDW-1:0]   last_id;
  logic             txn_write;
  logic [GW-1:0]    gap_cnt;
  // Completion is captured in WAIT and presented on req_done one edge later,
  // so all requester-facing pulses trail the state that produces them.
  logic             done_pend;
  logic             done_err;
  logic             arb_found;
  logic [IDW-1:0]   arb_id;

`ifdef TXN_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] tmo_cnt;
`endif

  assign dbg_state = state;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDW-1:0] id);
    onehot     = '0;
    onehot[id] = 1'b1;
  endfunction

  // Round-robin pick: first requesting index at or after last_id+1, wrapping.
  always_comb begin
    arb_found = 1'b0;
    arb_id    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!arb_found && req_valid[(int'(last_id) + 1 + i) % NUM_REQ]) begin
        arb_found = 1'b1;
        arb_id    = IDW'((int'(last_id) + 1 + i) % NUM_REQ);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      req_grant       <= '0;
      req_done        <= '0;
      req_error       <= 1'b0;
      start_write_txn <= 1'b0;
      start_read_txn  <= 1'b0;
      busy            <= 1'b0;
      active_id       <= '0;
      last_id         <= IDW'(NUM_REQ - 1);
      txn_write       <= 1'b0;
      gap_cnt         <= '0;
      done_pend       <= 1'b0;
      done_err        <= 1'b0;
`ifdef TXN_TIMEOUT_EN
      tmo_cnt         <= '0;
`endif
    end else begin
      req_grant       <= '0;
      start_write_txn <= 1'b0;
      start_read_txn  <= 1'b0;
      req_done        <= '0;
      req_error       <= 1'b0;
      done_pend       <= 1'b0;
      busy            <= (state != IDLE);

      // active_id is still the finished transaction's owner here, even if
      // IDLE re-arbitrates on this same edge (non-blocking read).
      if (done_pend) begin
        req_done  <= onehot(active_id);
        req_error <= done_err;
      end

      case (state)
        IDLE: begin
          if (arb_found) begin
            active_id <= arb_id;
            txn_write <= req_write[arb_id];
            state     <= LAUNCH;
          end
        end
        LAUNCH: begin
          req_grant       <= onehot(active_id);
          start_write_txn <= txn_write;
          start_read_txn  <= !txn_write;
`ifdef TXN_TIMEOUT_EN
          tmo_cnt         <= '0;
`endif
          state           <= WAIT;
        end
        WAIT: begin
`ifdef TXN_TIMEOUT_EN
          tmo_cnt <= tmo_cnt + TW'(1);
          // A real completion on the limit cycle wins over the timeout.
          if (txn_done || (tmo_cnt == TMO_LAST)) begin
            done_pend <= 1'b1;
            done_err  <= txn_done ? txn_error : 1'b1;
            last_id   <= active_id;
            gap_cnt   <= '0;
            state     <= (GAP_CYCLES == 0) ? IDLE : GAP;
          end
`else
          if (txn_done) begin
            done_pend <= 1'b1;
            done_err  <= txn_error;
            last_id   <= active_id;
            gap_cnt   <= '0;
            state     <= (GAP_CYCLES == 0) ? IDLE : GAP;
          end
`endif
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_txn_scheduler.sv
module tb_axi_txn_scheduler;

  localparam int NUM_REQ = 4;
  localparam int GAP     = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [NUM_REQ-1:0] req_valid = '0;
  logic [NUM_REQ-1:0] req_write = '0;
  logic [NUM_REQ-1:0] req_grant;
  logic [NUM_REQ-1:0] req_done;
  logic               req_error;
  logic               start_write_txn;
  logic               start_read_txn;
  logic               txn_done = 1'b0;
  logic               txn_error = 1'b0;
  logic               busy;
  logic [1:0]         active_id;
  logic [1:0]         dbg_state;

  axi_txn_scheduler #(
    .NUM_REQ(NUM_REQ),
    .GAP_CYCLES(GAP),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_write(req_write),
    .req_grant(req_grant),
    .req_done(req_done),
    .req_error(req_error),
    .start_write_txn(start_write_txn),
    .start_read_txn(start_read_txn),
    .txn_done(txn_done),
    .txn_error(txn_error),
    .busy(busy),
    .active_id(active_id),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_total = 0;
  int n_bad   = 0;
  logic [3:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Wait (bounded) until a grant is visible at a falling edge.
  task automatic wait_grant(input string tag);
    int n;
    n = 0;
    while (req_grant == '0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (req_grant == '0) check({tag, "_grant_timeout"}, 32'd0, 32'd1);
  endtask

  // Pulse txn_done for one cycle while in WAIT and check the reported completion.
  task automatic finish_txn(input string tag, input logic err, input logic [3:0] exp_done);
    txn_done  = 1'b1;
    txn_error = err;
    @(negedge clk);
    txn_done  = 1'b0;
    txn_error = 1'b0;
    check({tag, "_done_early"}, 32'(req_done), 32'd0);
    @(negedge clk);
    check({tag, "_done"}, 32'(req_done), 32'(exp_done));
    check({tag, "_err"}, 32'(req_error), 32'(err));
    @(negedge clk);
    check({tag, "_done_clr"}, 32'(req_done), 32'd0);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (dbg_state != 2'd0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (dbg_state != 2'd0) check({tag, "_idle_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin : main
    int last_cyc;
    logic [3:0] exp_id;

    // ---- reset state ----
    repeat (2) @(negedge clk);
    check("rst_grant", 32'(req_grant), 32'd0);
    check("rst_done", 32'(req_done), 32'd0);
    check("rst_swr", 32'(start_write_txn), 32'd0);
    check("rst_srd", 32'(start_read_txn), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_id", 32'(active_id), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // ---- single write from requester 0 ----
    req_valid = 4'b0001;
    req_write = 4'b0001;
    @(negedge clk);
    check("wr_launch_state", 32'(dbg_state), 32'd1);
    check("wr_busy_lag", 32'(busy), 32'd0);
    check("wr_grant_lag", 32'(req_grant), 32'd0);
    wait_grant("wr");
    check("wr_grant", 32'(req_grant), 32'b0001);
    check("wr_swr", 32'(start_write_txn), 32'd1);
    check("wr_srd", 32'(start_read_txn), 32'd0);
    check("wr_busy", 32'(busy), 32'd1);
    check("wr_id", 32'(active_id), 32'd0);
    req_valid = '0;
    req_write = '0;
    @(negedge clk);
    check("wr_pulse_1cyc", 32'(start_write_txn), 32'd0);
    repeat (4) @(negedge clk);
    check("wr_wait_state", 32'(dbg_state), 32'd2);
    finish_txn("wr", 1'b0, 4'b0001);

    // ---- error propagation: requester 2 read ----
    req_valid = 4'b0100;
    wait_grant("er");
    check("er_grant", 32'(req_grant), 32'b0100);
    check("er_srd", 32'(start_read_txn), 32'd1);
    check("er_swr", 32'(start_write_txn), 32'd0);
    req_valid = '0;
    finish_txn("er", 1'b1, 4'b0100);

    // ---- spurious done in IDLE ----
    wait_idle("sp");
    txn_done = 1'b1;
    @(negedge clk);
    txn_done = 1'b0;
    check("sp_idle_state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    check("sp_idle_done", 32'(req_done), 32'd0);
    check("sp_idle_state2", 32'(dbg_state), 32'd0);

    // ---- spurious done in LAUNCH, requester 3 write ----
    req_valid = 4'b1000;
    req_write = 4'b1000;
    @(negedge clk);
    check("sp_launch_state", 32'(dbg_state), 32'd1);
    txn_done = 1'b1;
    @(negedge clk);
    txn_done = 1'b0;
    check("sp_grant", 32'(req_grant), 32'b1000);
    check("sp_wait_state", 32'(dbg_state), 32'd2);
    req_valid = '0;
    req_write = '0;
    @(negedge clk);
    check("sp_launch_done", 32'(req_done), 32'd0);
    check("sp_still_wait", 32'(dbg_state), 32'd2);
    finish_txn("sp", 1'b0, 4'b1000);

    // ---- reset during WAIT (requester 1) ----
    req_valid = 4'b0010;
    wait_grant("rw");
    check("rw_grant", 32'(req_grant), 32'b0010);
    check("rw_id", 32'(active_id), 32'd1);
    req_valid = 4'b1111;
    @(negedge clk);
    check("rw_in_wait", 32'(dbg_state), 32'd2);
    reset = 1'b0;
    #1;
    check("rw_busy", 32'(busy), 32'd0);
    check("rw_id0", 32'(active_id), 32'd0);
    check("rw_state", 32'(dbg_state), 32'd0);
    check("rw_starts", 32'({start_write_txn, start_read_txn}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    check("rw_no_done", 32'(req_done), 32'd0);
    reset = 1'b1;

    // ---- round robin, all reads, held requests, immediate completion ----
    exp_q = {4'd0, 4'd1, 4'd2, 4'd3, 4'd0};
    last_cyc = 0;
    for (int i = 0; i < 5; i++) begin
      exp_id = exp_q.pop_front();
      wait_grant("rr");
      check($sformatf("rr%0d_grant", i), 32'(req_grant), 32'd1 << exp_id);
      check($sformatf("rr%0d_srd", i), 32'(start_read_txn), 32'd1);
      if (i > 0) check($sformatf("rr%0d_spacing", i), 32'(cyc - last_cyc), 32'(3 + GAP));
      last_cyc = cyc;
      finish_txn($sformatf("rr%0d", i), 1'b0, 4'd1 << exp_id);
    end
    req_valid = '0;
    wait_idle("rr");

`ifdef TXN_TIMEOUT_EN
    // ---- watchdog: write from requester 1, master never answers ----
    begin : tmo
      int n;
      req_valid = 4'b0010;
      req_write = 4'b0010;
      wait_grant("to");
      check("to_grant", 32'(req_grant), 32'b0010);
      req_valid = '0;
      req_write = '0;
      n = 0;
      while (req_done == '0 && n < 40) begin
        @(negedge clk);
        n++;
      end
      check("to_latency", 32'(n), 32'd17);
      check("to_done", 32'(req_done), 32'b0010);
      check("to_err", 32'(req_error), 32'd1);
      req_valid = 4'b0100;
      wait_grant("to_next");
      check("to_next_grant", 32'(req_grant), 32'b0100);
      req_valid = '0;
      finish_txn("to_next", 1'b0, 4'b0100);
    end
`endif

    // ---- final report ----
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // Global safety net so the run always ends on its own.
  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=%0d", cyc, 0);
    n_bad++;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
